// File: rtl/seven_segment_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package seven_segment_arbiter_pkg;

    // Arbiter ownership state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Ceiling log2; used to size the digit and hold counters.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_segment_arbiter_if.sv
// Requester/display bundle between the sources and the display arbiter.
interface seven_segment_arbiter_if #(
    parameter int unsigned w        = 32,
    parameter int unsigned n_digits = 8,
    parameter int unsigned n_src    = 4,
    parameter int unsigned div_w    = 16
);
    logic [div_w-1:0]          div;
    logic [n_src-1:0]          req;
    logic [n_src*w-1:0]        src_num;
    logic [n_src*n_digits-1:0] src_dots;
    logic                      en;
    logic [w-1:0]              num;
    logic [n_digits-1:0]       dots;
    logic [n_src-1:0]          gnt;
    logic                      frame_start;

    modport master (
        output div, req, src_num, src_dots,
        input  en, num, dots, gnt, frame_start
    );

    modport slave (
        input  div, req, src_num, src_dots,
        output en, num, dots, gnt, frame_start
    );
endinterface

// File: rtl/seven_segment_arbiter_round_robin_next.sv
// Combinational round-robin pick: searches from the index after the current
// owner (after the last index when idle) and returns a one-hot winner.
module round_robin_next
    import seven_segment_arbiter_pkg::*;
#(
    parameter int unsigned n_src = 4
) (
    input  logic [n_src-1:0] req,
    input  logic [n_src-1:0] gnt,
    input  logic             idle,
    output logic [n_src-1:0] winner,
    output logic             valid
);

    // Rotate the priority so the owner itself is considered last.
    always_comb begin
        int unsigned owner;
        int unsigned start;
        int unsigned pos;
        owner  = n_src - 1;
        winner = '0;
        valid  = 1'b0;
        if (!idle) begin
            for (int unsigned i = 0; i < n_src; i++) begin
                if (gnt[i]) owner = i;
            end
        end
        start = (owner + 1) % n_src;
        for (int unsigned k = 0; k < n_src; k++) begin
            pos = (start + k) % n_src;
            for (int unsigned i = 0; i < n_src; i++) begin
                if (!valid && (i == pos) && req[i]) begin
                    winner[i] = 1'b1;
                    valid     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seven_segment_arbiter.sv
// Shares one multiplexed seven-segment display among several requesters:
// refresh prescaler, digit sequencing, frame-aligned round-robin grant with
// a minimum hold, and a frame-coherent snapshot of the owner's value.
module seven_segment_arbiter
    import seven_segment_arbiter_pkg::*;
#(
    parameter int unsigned w              = 32,
    parameter int unsigned bits_per_digit = 4,
    parameter int unsigned n_digits       = w / bits_per_digit,
    parameter int unsigned n_src          = 4,
    parameter int unsigned div_w          = 16,
    parameter int unsigned hold_frames    = 16
) (
    input logic                   clk,
    input logic                   reset,
    seven_segment_arbiter_if.slave bus
);

    localparam int unsigned DIG_W  = (n_digits > 1) ? clog2(n_digits) : 1;
    localparam int unsigned HOLD_W = (hold_frames > 1) ? clog2(hold_frames) : 1;
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(n_digits - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(hold_frames - 1);

    logic [div_w-1:0]    cnt_q, cnt_d;
    logic                en_q, en_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [n_src-1:0]    gnt_q, gnt_d;
    logic [w-1:0]        num_q, num_d;
    logic [n_digits-1:0] dots_q, dots_d;
    logic                fs_q, fs_d;

    logic                boundary;
    logic                owner_req;
    logic [n_src-1:0]    rr_gnt;
    logic                rr_valid;

    round_robin_next #(
        .n_src(n_src)
    ) u_rr (
        .req   (bus.req),
        .gnt   (gnt_q),
        .idle  (state_q == ST_IDLE),
        .winner(rr_gnt),
        .valid (rr_valid)
    );

    // Prescaler and digit counter; >= lets a lowered div wrap at once.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        en_d  = 1'b0;
        if (cnt_q >= bus.div) begin
            cnt_d = '0;
            en_d  = 1'b1;
        end
        dig_d = dig_q;
        if (en_q) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end
    end

    assign boundary  = en_q && (dig_q == DIG_LAST);
    assign owner_req = |(bus.req & gnt_q);

    // Ownership FSM and snapshot; everything visible changes only at a boundary.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        num_d   = num_q;
        dots_d  = dots_q;
        fs_d    = 1'b0;
        if (boundary) begin
            fs_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (rr_valid) begin
                        state_d = ST_OWN;
                        gnt_d   = rr_gnt;
                        hold_d  = '0;
                    end
                end
                ST_OWN: begin
                    if (!owner_req) begin
                        hold_d = '0;
                        if (rr_valid) begin
                            gnt_d = rr_gnt;
                        end else begin
                            state_d = ST_IDLE;
                            gnt_d   = '0;
                        end
                    end else if ((hold_q >= HOLD_LAST) && rr_valid && (rr_gnt != gnt_q)) begin
                        gnt_d  = rr_gnt;
                        hold_d = '0;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    hold_d  = '0;
                end
            endcase
            num_d  = '0;
            dots_d = '0;
            for (int unsigned i = 0; i < n_src; i++) begin
                if (gnt_d[i]) begin
                    num_d  = num_d | bus.src_num[i*w +: w];
                    dots_d = dots_d | bus.src_dots[i*n_digits +: n_digits];
                end
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            en_q    <= 1'b0;
            dig_q   <= '0;
            state_q <= ST_IDLE;
            hold_q  <= '0;
            gnt_q   <= '0;
            num_q   <= '0;
            dots_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            dig_q   <= dig_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            num_q   <= num_d;
            dots_q  <= dots_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.en          = en_q;
    assign bus.gnt         = gnt_q;
    assign bus.num         = num_q;
    assign bus.dots        = dots_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Randomized self-checking bench for seven_segment_arbiter against a
// frame-level reference model.
module tb_seven_segment_arbiter;

    localparam int W  = 32;
    localparam int ND = 8;
    localparam int NS = 4;
    localparam int DW = 16;
    localparam int HF = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    seven_segment_arbiter_if #(.w(W), .n_digits(ND), .n_src(NS), .div_w(DW)) bus ();

    seven_segment_arbiter #(
        .w(W), .bits_per_digit(4), .n_digits(ND), .n_src(NS),
        .div_w(DW), .hold_frames(HF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: edge count since reset, owner index (-1 idle), frames held.
    int             m_t;
    int             m_owner;
    int             m_held;
    int             m_div;
    logic           exp_en, exp_fs;
    logic [NS-1:0]  exp_gnt;
    logic [W-1:0]   exp_num;
    logic [ND-1:0]  exp_dots;

    function automatic logic [45:0] got_vec();
        return {bus.en, bus.frame_start, bus.gnt, bus.num, bus.dots};
    endfunction

    function automatic logic [45:0] want_vec();
        return {exp_en, exp_fs, exp_gnt, exp_num, exp_dots};
    endfunction

    task model_reset();
        m_t = 0; m_owner = -1; m_held = 0;
        exp_en = 0; exp_fs = 0; exp_gnt = '0; exp_num = '0; exp_dots = '0;
    endtask

    task arbitrate(input logic [NS-1:0] r);
        int s, idx;
        bit found;
        if (m_owner < 0 || !r[m_owner]) begin
            s = (m_owner < 0) ? 0 : m_owner + 1;
            m_owner = -1; m_held = 0;
            for (int k = 0; k < NS; k++) begin
                idx = (s + k) % NS;
                if (r[idx]) begin m_owner = idx; break; end
            end
        end else if (m_held >= HF - 1) begin
            found = 0;
            for (int k = 1; k < NS; k++) begin
                idx = (m_owner + k) % NS;
                if (r[idx]) begin m_owner = idx; m_held = 0; found = 1; break; end
            end
            if (!found) m_held++;
        end else begin
            m_held++;
        end
    endtask

    // Advance one clock edge; expectations come from edge arithmetic.
    task step();
        logic [NS-1:0]    c_req;
        logic [NS*W-1:0]  c_num;
        logic [NS*ND-1:0] c_dots;
        int p;
        c_req = bus.req; c_num = bus.src_num; c_dots = bus.src_dots;
        @(posedge clk); #1;
        m_t++;
        p = m_div + 1;
        exp_en = ((m_t % p) == 0);
        exp_fs = 1'b0;
        if (m_t > 1 && ((m_t - 1) % p) == 0 && (((m_t - 1) / p) % ND) == 0) begin
            exp_fs = 1'b1;
            arbitrate(c_req);
            exp_gnt = '0; exp_num = '0; exp_dots = '0;
            if (m_owner >= 0) begin
                exp_gnt[m_owner] = 1'b1;
                exp_num  = c_num[m_owner*W +: W];
                exp_dots = c_dots[m_owner*ND +: ND];
            end
        end
    endtask

    task do_reset(input int d, input logic [NS-1:0] r);
        reset = 1'b1;
        bus.div = DW'(d); m_div = d;
        bus.req = r;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task randomize_sources();
        bus.src_num  = {$urandom, $urandom, $urandom, $urandom};
        bus.src_dots = $urandom;
    endtask

    task test_reset();
        randomize_sources();
        bus.req = 4'b1111; bus.div = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (got_vec() !== 46'd0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", got_vec());
        end
    endtask

    task test_prescaler();
        int ens;
        ens = 0;
        do_reset(3, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.en === 1'b1) ens++;
            total++;
            if (got_vec() !== want_vec()) begin
                bad++;
                $display("FAIL prescaler t=%0d got=%h want=%h", m_t, got_vec(), want_vec());
            end
        end
        total++;
        if (ens !== 10) begin
            bad++;
            $display("FAIL prescaler_count got=%0d want=10", ens);
        end
    endtask

    task test_single();
        randomize_sources();
        bus.src_num[2*W +: W] = 32'h1234_5678;
        do_reset(0, 4'b0100);
        for (int i = 0; i < 100 * ND + 16; i++) begin
            step();
            total++;
            if (got_vec() !== want_vec()) begin
                bad++;
                $display("FAIL single t=%0d got=%h want=%h", m_t, got_vec(), want_vec());
            end
            if (bus.frame_start === 1'b1) begin
                total++;
                if (bus.gnt !== 4'b0100 || bus.num !== 32'h1234_5678) begin
                    bad++;
                    $display("FAIL single_grant t=%0d gnt=%b num=%h want gnt=0100 num=12345678", m_t, bus.gnt, bus.num);
                end
            end
        end
    endtask

    task test_rotation();
        logic [NS-1:0] seq[$];
        logic [NS-1:0] want_seq [8];
        int d;
        want_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
        d = $urandom_range(0, 1);
        randomize_sources();
        do_reset(d, 4'b1011);
        for (int i = 0; i < 9 * (d + 1) * ND + 2; i++) begin
            step();
            total++;
            if (got_vec() !== want_vec()) begin
                bad++;
                $display("FAIL rotation t=%0d got=%h want=%h", m_t, got_vec(), want_vec());
            end
            if (bus.frame_start === 1'b1) seq.push_back(bus.gnt);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= seq.size()) begin
                bad++;
                $display("FAIL rotation_order frame=%0d got=none want=%b", i, want_seq[i]);
            end else if (seq[i] !== want_seq[i]) begin
                bad++;
                $display("FAIL rotation_order frame=%0d got=%b want=%b", i, seq[i], want_seq[i]);
            end
        end
    endtask

    task test_owner_drop();
        logic [W-1:0] held_num;
        int n;
        randomize_sources();
        do_reset(1, 4'b1010);
        for (n = 0; n < 300 && bus.frame_start !== 1'b1; n++) step();
        total++;
        if (bus.gnt !== 4'b0010) begin
            bad++;
            $display("FAIL drop_first_owner gnt=%b want=0010 after=%0d", bus.gnt, n);
        end
        repeat (3) step();
        held_num = bus.num;
        bus.req = 4'b1000;
        for (n = 0; n < 300; n++) begin
            step();
            total++;
            if (got_vec() !== want_vec()) begin
                bad++;
                $display("FAIL drop t=%0d got=%h want=%h", m_t, got_vec(), want_vec());
            end
            if (bus.frame_start === 1'b1) break;
            total++;
            if (bus.gnt !== 4'b0010 || bus.num !== held_num) begin
                bad++;
                $display("FAIL drop_midframe gnt=%b num=%h want gnt=0010 num=%h", bus.gnt, bus.num, held_num);
            end
        end
        total++;
        if (bus.frame_start !== 1'b1 || bus.gnt !== 4'b1000) begin
            bad++;
            $display("FAIL drop_handover fs=%b gnt=%b want fs=1 gnt=1000", bus.frame_start, bus.gnt);
        end
    endtask

    task test_coherence();
        logic [W-1:0] old_v, new_v;
        int n;
        randomize_sources();
        old_v = bus.src_num[W-1:0];
        do_reset(0, 4'b0001);
        for (n = 0; n < 300 && bus.frame_start !== 1'b1; n++) step();
        total++;
        if (bus.num !== old_v) begin
            bad++;
            $display("FAIL coherence_first num=%h want=%h", bus.num, old_v);
        end
        repeat (3) step();
        new_v = ~old_v ^ 32'h5a5a_0f0f;
        bus.src_num[W-1:0] = new_v;
        for (n = 0; n < 300; n++) begin
            step();
            if (bus.frame_start === 1'b1) break;
            total++;
            if (bus.num !== old_v) begin
                bad++;
                $display("FAIL coherence_midframe num=%h want=%h", bus.num, old_v);
            end
        end
        total++;
        if (bus.frame_start !== 1'b1 || bus.num !== new_v) begin
            bad++;
            $display("FAIL coherence_update fs=%b num=%h want fs=1 num=%h", bus.frame_start, bus.num, new_v);
        end
    endtask

    task test_random();
        int s;
        randomize_sources();
        do_reset($urandom_range(0, 2), NS'($urandom));
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) bus.req = NS'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                s = $urandom_range(0, NS - 1);
                bus.src_num[s*W +: W]   = $urandom;
                bus.src_dots[s*ND +: ND] = ND'($urandom);
            end
            step();
            total++;
            if (got_vec() !== want_vec()) begin
                bad++;
                $display("FAIL random t=%0d got=%h want=%h", m_t, got_vec(), want_vec());
            end
        end
    endtask

    task test_reset_mid();
        int n;
        randomize_sources();
        do_reset(0, 4'b0110);
        repeat (20) step();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (got_vec() !== 46'd0) begin
            bad++;
            $display("FAIL reset_mid_clear got=%h want=0", got_vec());
        end
        bus.req = 4'b1111;
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        for (n = 0; n < 300; n++) begin
            step();
            total++;
            if (got_vec() !== want_vec()) begin
                bad++;
                $display("FAIL reset_mid t=%0d got=%h want=%h", m_t, got_vec(), want_vec());
            end
            if (bus.frame_start === 1'b1) break;
        end
        total++;
        if (bus.frame_start !== 1'b1 || bus.gnt !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid_first fs=%b gnt=%b want fs=1 gnt=0001", bus.frame_start, bus.gnt);
        end
    endtask

    initial begin
        bus.div = '0;
        bus.req = '0;
        bus.src_num = '0;
        bus.src_dots = '0;
        model_reset();
        test_reset();
        test_prescaler();
        test_single();
        test_rotation();
        test_owner_drop();
        test_coherence();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_segment_arbiter.md
# seven_segment_arbiter

Shares one multiplexed seven-segment display between `n_src` requesters and sequences its refresh. Generates the per-digit refresh strobe `en` from a programmable prescaler. Grants the display round-robin with a minimum hold time measured in whole refresh frames. Presents a frame-coherent snapshot of the granted source's `num`/`dots` to the downstream `seven_segment` instance.

## Interface
- `w`, 32: display value width in bits.
- `bits_per_digit`, 4: bits per displayed digit.
- `n_digits`, `w / bits_per_digit`: digits per frame.
- `n_src`, 4: number of requesters, ≥ 2.
- `div_w`, 16: prescaler width.
- `hold_frames`, 16: minimum frames a grant is held while others wait, ≥ 1.

- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `div`  in  `div_w`: refresh period minus one, in clocks.
- `req`  in  `n_src`: level request per source.
- `src_num`  in  `n_src*w`: source i value at bits `[i*w +: w]`.
- `src_dots`  in  `n_src*n_digits`: source i dots at bits `[i*n_digits +: n_digits]`.
- `en`  out  1: one-cycle refresh strobe, drives `seven_segment.en`.
- `num`  out  `w`: displayed value.
- `dots`  out  `n_digits`: displayed dots.
- `gnt`  out  `n_src`: one-hot current owner, all zero when idle.
- `frame_start`  out  1: one-cycle pulse, first cycle a new frame's data is visible.

## Operation
- Prescaler `cnt`: up-counter.
  - When `cnt >= div`: clear `cnt`; pulse `en` next cycle.
  - Otherwise: increment `cnt`.
  - The `>=` compare makes a `div` decrease mid-count wrap immediately, never overflow.
- Digit counter `dig`: 0..`n_digits-1`, advances on each `en` and wraps.
  - Boundary = cycle where `en` is high and `dig == n_digits-1`.
- States:
  - IDLE: `gnt=0`, `num=0`, `dots=0`.
  - OWN: one source granted; `hold_cnt` counts completed frames.
- Arbitration runs only at a boundary; `gnt`, `num` and `dots` never change mid-frame. Candidate search is round-robin, starting at the index after the current owner (after index `n_src-1` when idle).
  - IDLE, any `req`: grant the first requester found → OWN, `hold_cnt=0`.
  - IDLE, no `req`: stay IDLE.
  - OWN, owner `req` low: grant the next requester → OWN, `hold_cnt=0`; no requester → IDLE.
  - OWN, owner `req` high, `hold_cnt >= hold_frames-1`, another `req` high: rotate to it, `hold_cnt=0`.
  - OWN, otherwise: keep the owner; `hold_cnt` increments, saturating.
- Snapshot: at every boundary, latch `num`/`dots` from the owner selected for the next frame. Source changes mid-frame are invisible until the next boundary.
- Lone requester: keeps the grant indefinitely.
- `req` pulses that begin and end inside one frame are not seen.

## Timing
- Reset values: `en=0`, `num=0`, `dots=0`, `gnt=0`, `frame_start=0`, `cnt=0`, `dig=0`, `hold_cnt=0`, state IDLE.
- First `en` is high in the cycle after the (`div`+1)-th clock edge following reset release. `div=0` gives `en` every cycle.
- `en`, `gnt`, `num`, `dots` and `frame_start` are all registered.
- At the boundary clock edge, `gnt`/`num`/`dots` update together, and `frame_start` is high for exactly that following cycle.
- Request-to-display latency from IDLE: at most one frame plus one cycle.
- Reset asserted mid-frame clears all state asynchronously. After release, arbitration restarts from IDLE with the pointer at index 0 first.
- `div` is sampled every cycle; a change takes effect on the current count.

## Structure
- Shared package/header holds:
  - state encoding constants `ST_IDLE`, `ST_OWN`;
  - `clog2` helper for `dig`/`hold_cnt` widths.
- One sub-module, `round_robin_next`: combinational next-grant from `req`, current one-hot `gnt`, and an idle flag. It returns the one-hot winner plus a valid bit.
- Top level holds the prescaler, digit counter, FSM, hold counter and output registers.

## Test plan
- Prescaler: `div=3`, no `req` → `en` high every 4th cycle; `gnt=0` and `num=0` throughout.
- Single requester: `n_digits=8`, `div=0`, only `req[2]`, `src_num[2]=32'h1234_5678` → at the first boundary `gnt=4'b0100`, `num=32'h1234_5678`, `frame_start` pulses. Grant is held across 100 frames.
- Hold and rotation: `hold_frames=2`, `req=4'b1011` constant → owner order 0,1,3,0, each held exactly 2 frames.
- Owner drops: with `req[1]` owner, drop it mid-frame while `req[3]` is high → `gnt` and `num` unchanged until the boundary, then `gnt=4'b1000`.
- Coherence: change `src_num` of the owner mid-frame → `num` updates only on the next boundary edge.
- Reset mid-frame: outputs zero in the same cycle; after release, `req=4'b1111` grants source 0 first.
